// File: rtl/sdram_uart_dumper_pkg.sv
// Shared state encodings and byte constants for the SDRAM-to-UART dump path.
// The trailer states exist only when DUMP_TRAILER_EN is defined.
package sdram_uart_dumper_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam logic [7:0] TRAILER_BYTE      = 8'h5A;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_TX_SYNC,
    ST_TX_B3,
    ST_TX_B2,
    ST_TX_B1,
    ST_TX_B0,
`ifdef DUMP_TRAILER_EN
    ST_TRL_A,
    ST_TRL_B,
    ST_TRL_SUM,
`endif
    ST_DONE,
    ST_ERROR
  } dump_state_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_SENT,
    HS_GUARD
  } hs_state_e;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] byte_sum(input logic [31:0] w);
    return w[31:24] + w[23:16] + w[15:8] + w[7:0];
  endfunction

endpackage

// File: rtl/dump_tx_handshake.sv
// One-byte UART sequencer: waits for tx_ready, pulses tx_en for one cycle,
// then spends one guard cycle before reporting ack and returning to idle.
module dump_tx_handshake
  import sdram_uart_dumper_pkg::*;
(
  input  logic       clk100,
  input  logic       rst_p,
  input  logic       req,
  input  logic [7:0] byte_in,
  input  logic       tx_ready,
  output logic [7:0] tx_byte,
  output logic       tx_en,
  output logic       idle,
  output logic       ack
);

  hs_state_e  hs_q, hs_d;
  logic [7:0] byte_q, byte_d;

  always_ff @(posedge clk100 or posedge rst_p) begin
    if (rst_p) begin
      hs_q   <= HS_IDLE;
      byte_q <= 8'h00;
    end else begin
      hs_q   <= hs_d;
      byte_q <= byte_d;
    end
  end

  // The parent holds req and byte_in steady while idle, so no separate wait state is needed.
  always_comb begin
    hs_d   = hs_q;
    byte_d = byte_q;
    case (hs_q)
      HS_IDLE: begin
        if (req && tx_ready) begin
          hs_d   = HS_SENT;
          byte_d = byte_in;
        end
      end
      HS_SENT:  hs_d = HS_GUARD;
      HS_GUARD: hs_d = HS_IDLE;
      default:  hs_d = HS_IDLE;
    endcase
  end

  assign tx_byte = byte_q;
  assign tx_en   = (hs_q == HS_SENT);
  assign idle    = (hs_q == HS_IDLE);
  assign ack     = (hs_q == HS_GUARD);

endmodule

// File: rtl/sdram_uart_dumper.sv
// Reads SDRAM words from address 0 upward and streams each as SYNC_BYTE + 4 data bytes to the UART.
// Define DUMP_TRAILER_EN to append 5A 5A <modulo-256 data byte sum> before DONE.
module sdram_uart_dumper
  import sdram_uart_dumper_pkg::*;
#(
  parameter int unsigned ADDR_W     = 23,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  parameter int unsigned RD_TIMEOUT = 1024
) (
  input  logic              clk100,
  input  logic              rst_p,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              cmd_ready,
  output logic              cmd_enable,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_address,
  input  logic [31:0]       data_out,
  input  logic              data_out_ready,
  output logic [7:0]        tx_byte,
  output logic              tx_en,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int TMR_W = $clog2(RD_TIMEOUT + 1);

`ifdef DUMP_TRAILER_EN
  localparam dump_state_e ST_FINISH = ST_TRL_A;
`else
  localparam dump_state_e ST_FINISH = ST_DONE;
`endif

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [31:0]       word_q, word_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              abort_q, abort_d;
`ifdef DUMP_TRAILER_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic        hs_req, hs_idle, hs_ack;
  logic [7:0]  hs_byte;
  logic        send;
  dump_state_e after_byte;
  logic        abort_hit;
  logic        last_word;
  logic        cmd_enable_c;

  always_ff @(posedge clk100 or posedge rst_p) begin
    if (rst_p) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      word_q  <= '0;
      timer_q <= '0;
      abort_q <= 1'b0;
`ifdef DUMP_TRAILER_EN
      sum_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      word_q  <= word_d;
      timer_q <= timer_d;
      abort_q <= abort_d;
`ifdef DUMP_TRAILER_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // A same-cycle abort pulse counts, so abort with data_out_ready skips TX_SYNC.
  assign abort_hit = abort_q | abort;
  // A cleared word (bit0 == 0) ends the dump as early as reaching last_addr does.
  assign last_word = (addr_q == last_q) || !word_q[0];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    last_d       = last_q;
    word_d       = word_q;
    timer_d      = timer_q;
    abort_d      = abort_q | (abort & busy);
`ifdef DUMP_TRAILER_EN
    sum_d        = sum_q;
`endif
    cmd_enable_c = 1'b0;
    hs_req       = 1'b0;
    hs_byte      = 8'h00;
    send         = 1'b0;
    after_byte   = state_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_RD_REQ;
          addr_d  = '0;
          last_d  = last_addr;
`ifdef DUMP_TRAILER_EN
          sum_d   = 8'h00;
`endif
        end
      end
      ST_RD_REQ: begin
        if (abort_hit) begin
          state_d = ST_DONE;
        end else if (cmd_ready) begin
          cmd_enable_c = 1'b1;
          timer_d      = TMR_W'(1);
          state_d      = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (data_out_ready) begin
          word_d  = data_out;
`ifdef DUMP_TRAILER_EN
          sum_d   = sum_q + byte_sum(data_out);
`endif
          state_d = abort_hit ? ST_DONE : ST_TX_SYNC;
        end else if (timer_q == TMR_W'(RD_TIMEOUT - 1)) begin
          state_d = ST_ERROR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_TX_SYNC: begin
        send = 1'b1; hs_byte = SYNC_BYTE; after_byte = ST_TX_B3;
      end
      ST_TX_B3: begin
        send = 1'b1; hs_byte = word_byte(word_q, 2'd3); after_byte = ST_TX_B2;
      end
      ST_TX_B2: begin
        send = 1'b1; hs_byte = word_byte(word_q, 2'd2); after_byte = ST_TX_B1;
      end
      ST_TX_B1: begin
        send = 1'b1; hs_byte = word_byte(word_q, 2'd1); after_byte = ST_TX_B0;
      end
      ST_TX_B0: begin
        send       = 1'b1;
        hs_byte    = word_byte(word_q, 2'd0);
        after_byte = last_word ? ST_FINISH : ST_RD_REQ;
        if (hs_ack && !last_word) addr_d = addr_q + ADDR_W'(1);
      end
`ifdef DUMP_TRAILER_EN
      ST_TRL_A: begin
        send = 1'b1; hs_byte = TRAILER_BYTE; after_byte = ST_TRL_B;
      end
      ST_TRL_B: begin
        send = 1'b1; hs_byte = TRAILER_BYTE; after_byte = ST_TRL_SUM;
      end
      ST_TRL_SUM: begin
        send = 1'b1; hs_byte = sum_q; after_byte = ST_DONE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Byte boundary: an idle sequencer means no byte is in flight, so abort can stop here.
    if (send) begin
      if (hs_idle) begin
        if (abort_hit) state_d = ST_DONE;
        else           hs_req  = 1'b1;
      end else if (hs_ack) begin
        state_d = after_byte;
      end
    end

    if (state_d inside {ST_IDLE, ST_DONE, ST_ERROR}) abort_d = 1'b0;
  end

  dump_tx_handshake u_tx (
    .clk100   (clk100),
    .rst_p    (rst_p),
    .req      (hs_req),
    .byte_in  (hs_byte),
    .tx_ready (tx_ready),
    .tx_byte  (tx_byte),
    .tx_en    (tx_en),
    .idle     (hs_idle),
    .ack      (hs_ack)
  );

  assign cmd_enable  = cmd_enable_c;
  assign cmd_wr      = 1'b0;
  assign cmd_address = addr_q;
  assign busy        = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign done        = (state_q == ST_DONE);
  assign error       = (state_q == ST_ERROR);

endmodule

// File: tb/tb_sdram_uart_dumper.sv
// Directed bench for sdram_uart_dumper: SDRAM read responder and UART sink models check
// against scoreboard queues filled when each dump is set up.
module tb_sdram_uart_dumper;

  logic        clk100 = 1'b0;
  logic        rst_p, start, abort;
  logic [22:0] last_addr;
  logic        cmd_ready, cmd_enable, cmd_wr;
  logic [22:0] cmd_address;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic [7:0]  tx_byte;
  logic        tx_en, tx_ready;
  logic        busy, done, error;

  logic [31:0] mem [0:15];
  logic [7:0]  exp_q[$];
  logic [22:0] exp_addr_q[$];
  logic [7:0]  exp_sum;
  int          n_pass = 0;
  int          n_checks = 0;
  int          n_cmd = 0;
  bit          withhold = 1'b0;

  bit          rsp_pend = 1'b0;
  int          rsp_dly = 0;
  logic [3:0]  rsp_addr = 4'd0;
  int          uart_busy = 0;
  logic        prev_en = 1'b0;

  always #5 clk100 = ~clk100;

  sdram_uart_dumper dut (
    .clk100         (clk100),
    .rst_p          (rst_p),
    .start          (start),
    .abort          (abort),
    .last_addr      (last_addr),
    .cmd_ready      (cmd_ready),
    .cmd_enable     (cmd_enable),
    .cmd_wr         (cmd_wr),
    .cmd_address    (cmd_address),
    .data_out       (data_out),
    .data_out_ready (data_out_ready),
    .tx_byte        (tx_byte),
    .tx_en          (tx_en),
    .tx_ready       (tx_ready),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk100);
    #2;
  endtask

  task automatic begin_dump();
    exp_sum = 8'h00;
  endtask

  task automatic push_word(input logic [31:0] w, input logic [22:0] a);
    exp_addr_q.push_back(a);
    exp_q.push_back(8'hA5);
    for (int i = 3; i >= 0; i--) begin
      exp_q.push_back(w[i*8 +: 8]);
      exp_sum = exp_sum + w[i*8 +: 8];
    end
  endtask

  task automatic end_dump();
`ifdef DUMP_TRAILER_EN
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h5A);
    exp_q.push_back(exp_sum);
`endif
  endtask

  task automatic pulse_start(input logic [22:0] la);
    last_addr = la;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    check(tag, done, 1);
  endtask

  // SDRAM read port: random cmd_ready, data returned three cycles after an accepted command.
  initial begin : sdram_model
    cmd_ready = 1'b0;
    data_out = '0;
    data_out_ready = 1'b0;
    forever begin
      @(negedge clk100);
      data_out_ready = 1'b0;
      if (rsp_pend) begin
        if (rsp_dly == 0) begin
          data_out = mem[rsp_addr];
          data_out_ready = 1'b1;
          rsp_pend = 1'b0;
        end else begin
          rsp_dly--;
        end
      end
      cmd_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (rst_p) begin
        rsp_pend = 1'b0;
      end else if (cmd_enable) begin
        n_cmd++;
        $display("[%0t] read addr %0d", $time, cmd_address);
        check("cmd_wr", cmd_wr, 0);
        check("cmd_expected", exp_addr_q.size() != 0, 1);
        if (exp_addr_q.size() != 0) check("cmd_address", cmd_address, exp_addr_q.pop_front());
        rsp_pend = !withhold;
        rsp_dly = 2;
        rsp_addr = cmd_address[3:0];
      end
    end
  end

  // UART sink: random busy time after every byte; checks each byte against the scoreboard.
  initial begin : uart_model
    tx_ready = 1'b1;
    forever begin
      @(negedge clk100);
      #1;
      if (rst_p) begin
        uart_busy = 0;
        tx_ready = 1'b1;
        prev_en = 1'b0;
      end else begin
        if (tx_en) begin
          $display("[%0t] uart byte %02h", $time, tx_byte);
          check("tx_ready_at_send", tx_ready, 1);
          check("tx_en_single_cycle", prev_en, 0);
          check("tx_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("tx_byte", tx_byte, exp_q.pop_front());
          uart_busy = $urandom_range(0, 4);
          tx_ready = (uart_busy == 0);
        end else if (uart_busy > 0) begin
          uart_busy--;
          tx_ready = (uart_busy == 0);
        end
        prev_en = tx_en;
      end
    end
  end

  initial begin : main
    int n;
    rst_p = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    last_addr = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_tx_en", tx_en, 0);
    check("rst_cmd_enable", cmd_enable, 0);
    check("rst_cmd_wr", cmd_wr, 0);
    check("rst_cmd_address", cmd_address, 0);
    check("rst_tx_byte", tx_byte, 0);
    rst_p = 1'b0;
    step();

    // Three-word dump; a second start while busy must be ignored.
    mem[0] = 32'h12345671; mem[1] = 32'h00000003; mem[2] = 32'hFFFFFFFF;
    begin_dump();
    push_word(mem[0], 0); push_word(mem[1], 1); push_word(mem[2], 2);
    end_dump();
    n_cmd = 0;
    pulse_start(23'd2);
    check("t1_busy", busy, 1);
    repeat (20) step();
    pulse_start(23'd0);
    wait_done("t1_done", 3000);
    check("t1_bytes_left", exp_q.size(), 0);
    check("t1_cmd_count", n_cmd, 3);
    check("t1_busy_after", busy, 0);
    repeat (5) step();
    check("t1_done_held", done, 1);

    // Cleared word (bit0 == 0) ends the dump early.
    mem[0] = 32'h89ABCDEF; mem[1] = 32'h00000002; mem[2] = 32'h00000055;
    begin_dump();
    push_word(mem[0], 0); push_word(mem[1], 1);
    end_dump();
    n_cmd = 0;
    pulse_start(23'd10);
    wait_done("t2_done", 3000);
    check("t2_bytes_left", exp_q.size(), 0);
    check("t2_cmd_count", n_cmd, 2);

    // Read timeout: no data ever returned.
    withhold = 1'b1;
    exp_addr_q.push_back(0);
    n_cmd = 0;
    pulse_start(23'd0);
    n = 0;
    while (!cmd_enable && n < 100) begin
      step();
      n++;
    end
    check("t3_cmd_seen", cmd_enable, 1);
    n = 0;
    while (!error && n < 2000) begin
      step();
      n++;
    end
    check("t3_timeout_cycles", n, 1024);
    check("t3_error", error, 1);
    check("t3_busy", busy, 0);
    check("t3_done", done, 0);
    withhold = 1'b0;

    // Abort during the second data byte of word 0.
    mem[0] = 32'h12345671; mem[1] = 32'h0000000F;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_addr_q.push_back(0);
    n_cmd = 0;
    pulse_start(23'd1);
    check("t4_error_cleared", error, 0);
    n = 0;
    while (!(tx_en && tx_byte == 8'h34) && n < 500) begin
      step();
      n++;
    end
    check("t4_second_byte_seen", tx_en, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_done("t4_done", 200);
    repeat (20) step();
    check("t4_bytes_left", exp_q.size(), 0);
    check("t4_cmd_count", n_cmd, 1);

    // Abort while DONE is ignored; last_addr = 0 gives exactly one word.
    abort = 1'b1;
    step();
    abort = 1'b0;
    mem[0] = 32'hDEADBEEF;
    begin_dump();
    push_word(mem[0], 0);
    end_dump();
    n_cmd = 0;
    pulse_start(23'd0);
    wait_done("t2b_done", 2000);
    check("t2b_bytes_left", exp_q.size(), 0);
    check("t2b_cmd_count", n_cmd, 1);

`ifdef DUMP_TRAILER_EN
    mem[0] = 32'h01020305;
    exp_addr_q.push_back(0);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'h03); exp_q.push_back(8'h05);
    exp_q.push_back(8'h5A); exp_q.push_back(8'h5A); exp_q.push_back(8'h0B);
    pulse_start(23'd0);
    wait_done("t5_done", 2000);
    check("t5_bytes_left", exp_q.size(), 0);
`endif

    // Reset while waiting to send word[23:16], then a fresh dump from address 0.
    mem[0] = 32'hCAFEBAB1; mem[1] = 32'h13579BDF;
    exp_q.push_back(8'hA5); exp_q.push_back(8'hCA);
    exp_addr_q.push_back(0);
    pulse_start(23'd1);
    n = 0;
    while (!(tx_en && tx_byte == 8'hCA) && n < 500) begin
      step();
      n++;
    end
    check("t6_b3_seen", tx_en, 1);
    step();
    step();
    rst_p = 1'b1;
    #1;
    check("t6_rst_tx_en", tx_en, 0);
    check("t6_rst_cmd_enable", cmd_enable, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_bytes_left", exp_q.size(), 0);
    repeat (2) step();
    rst_p = 1'b0;
    step();
    begin_dump();
    push_word(mem[0], 0); push_word(mem[1], 1);
    end_dump();
    n_cmd = 0;
    pulse_start(23'd1);
    wait_done("t6_done", 3000);
    check("t6_restart_bytes_left", exp_q.size(), 0);
    check("t6_restart_cmd_count", n_cmd, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
